// File: rtl/seq_mult_8x8.sv
// Sequential unsigned 8x8 shift-and-add multiplier, one partial product per clock.
// Each RUN cycle feeds product/mcand through a 16-bit ripple-carry adder and registers its sum.

module rca_16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_s,
   output logic        o_cout
);
   logic [16:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < 16; g++) begin : g_fa
      assign o_s[g]     = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g + 1] = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[16];
endmodule

// state  | meaning
// IDLE   | waiting for start; product holds last result
// RUN    | eight shift-and-add iterations
// DONE   | single-cycle done pulse, product valid
module seq_mult_8x8 #(
   parameter int N     = 8,
   parameter int CNT_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] product,
   output logic           busy,
   output logic           done
);
   localparam int W = 2 * N;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [W-1:0]     r_mcand;
   logic [N-1:0]     r_mplier;
   logic [W-1:0]     r_product;
   logic [CNT_W-1:0] r_count;
   logic [W-1:0]     w_sum;
   // Product never exceeds 0xFE01, so the carry-out stays low and is not consumed.
   logic             w_cout_unused;

   rca_16 u_rca (
      .i_a    (r_product),
      .i_b    (r_mcand),
      .i_cin  (1'b0),
      .o_s    (w_sum),
      .o_cout (w_cout_unused)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (r_count == CNT_W'(N - 1)) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_product <= '0;
         r_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand   <= {{N{1'b0}}, a};
                  r_mplier  <= b;
                  r_product <= '0;
                  r_count   <= '0;
               end
            end
            S_RUN: begin
               if (r_mplier[0]) r_product <= w_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_count  <= r_count + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign product = r_product;
   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
endmodule
